// File: rtl/axi_ads124x_spi_master.sv
// Byte-level SPI mode-1 master for the ADS124x: AXI-Stream bytes in, received bytes out.
// Optional build macro ADS124X_SPI_LOOPBACK_EN samples the registered DIN instead of DOUT.
module axi_ads124x_spi_master #(
  parameter int C_SCLK_HALF = 8,
  parameter int C_CS_SETUP  = 4,
  parameter int C_CS_HOLD   = 16,
  parameter int C_CS_IDLE   = 8
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       SCLK,
  output logic       CS_N,
  output logic       DIN,
  input  logic       DOUT,
  output logic [2:0] dbg_state_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] HALF_LAST  = 16'(C_SCLK_HALF - 1);
  // The accepting S_READY cycle is the last setup cycle, so S_SETUP itself runs one short.
  localparam logic [15:0] SETUP_LAST = 16'((C_CS_SETUP >= 2) ? (C_CS_SETUP - 2) : 0);
  localparam logic [15:0] HOLD_LAST  = 16'(C_CS_HOLD - 1);
  localparam logic [15:0] IDLE_LOAD  = 16'(C_CS_IDLE);

  // Valid/ready: a byte moves on either stream only in a cycle where tvalid and tready are
  // both high at the rising aclk edge; tvalid never drops and tdata never changes before that.
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        din_q, din_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        rx_bit;
  logic        s_ready;
  logic        s_fire;

`ifdef ADS124X_SPI_LOOPBACK_EN
  logic loopback_unused;
  assign loopback_unused = DOUT;
  assign rx_bit          = din_q;
`else
  logic dout_q;
  always_ff @(posedge aclk) begin
    if (!aresetn) dout_q <= 1'b0;
    else          dout_q <= DOUT;
  end
  assign rx_bit = dout_q;
`endif

  assign s_ready = (state_q == S_READY) && !m_valid_q;
  assign s_fire  = s_ready && s_axis_tvalid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    din_d     = din_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        din_d  = 1'b0;
        cs_n_d = 1'b1;
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (s_axis_tvalid) begin
          state_d = S_SETUP;
          cs_n_d  = 1'b0;
          cnt_d   = 16'd0;
        end
      end
      S_SETUP: begin
        if (cnt_q >= SETUP_LAST) begin
          state_d = S_READY;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_READY: begin
        sclk_d = 1'b0;
        din_d  = 1'b0;
        // A transfer beats a simultaneous hold timeout; the hold count freezes under backpressure.
        if (s_fire) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          din_d   = s_axis_tdata[7];
          tx_d    = {s_axis_tdata[6:0], 1'b0};
          bit_d   = 3'd0;
          cnt_d   = 16'd0;
        end else if (!m_valid_q) begin
          if (cnt_q >= HOLD_LAST) begin
            state_d = S_IDLE;
            cs_n_d  = 1'b1;
            cnt_d   = IDLE_LOAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q >= HALF_LAST) begin
          cnt_d = 16'd0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            rx_d   = {rx_q[6:0], rx_bit};
          end else if (bit_q == 3'd7) begin
            state_d = S_DONE;
            din_d   = 1'b0;
          end else begin
            sclk_d = 1'b1;
            din_d  = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
            bit_d  = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        m_data_d  = rx_q;
        m_valid_d = 1'b1;
        state_d   = S_READY;
        cnt_d     = 16'd0;
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
        cnt_d   = IDLE_LOAD;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= IDLE_LOAD;
      bit_q     <= 3'd0;
      tx_q      <= 8'd0;
      rx_q      <= 8'd0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      din_q     <= 1'b0;
      m_data_q  <= 8'd0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      din_q     <= din_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign SCLK          = sclk_q;
  assign CS_N          = cs_n_q;
  assign DIN           = din_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axi_ads124x_spi_master.sv
// Bench for axi_ads124x_spi_master: ADC model on the pins, byte-stream reference queues.
// Build with ADS124X_SPI_LOOPBACK_EN to expect the transmitted byte echoed back.
`timescale 1ns/1ps
module tb_axi_ads124x_spi_master;

  localparam int HALF  = 8;
  localparam int SETUP = 4;
  localparam int HOLD  = 16;
  localparam int IDLE  = 8;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic [7:0] s_axis_tdata = 8'd0;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       SCLK, CS_N, DIN;
  logic       DOUT = 1'b0;
  logic [2:0] dbg_state;

  axi_ads124x_spi_master #(
    .C_SCLK_HALF(HALF), .C_CS_SETUP(SETUP), .C_CS_HOLD(HOLD), .C_CS_IDLE(IDLE)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .SCLK(SCLK), .CS_N(CS_N), .DIN(DIN), .DOUT(DOUT), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // reference queues and counters
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] got_rx[$];
  logic [7:0] got_tx[$];
  int errors = 0;
  int checks = 0;
  int rx_rd = 0;
  int tx_rd = 0;

  // pin monitor and ADC model: DOUT shifts out MSB-first after each SCLK rise
  int cyc = 0;
  int sclk_rises = 0, cs_falls = 0, cs_rises = 0;
  int cs_fall_cyc = 0, cs_rise_cyc = 0, first_rise_cyc = 0, tv_rise_cyc = 0;
  int last_idle_gap = 0;
  int tx_bits = 0, bitpos = 0, resp_rd = 0;
  logic [7:0] tx_sh = 8'd0, cur_resp = 8'd0;
  logic sclk_prev = 1'b0, cs_prev = 1'b1, tv_prev = 1'b0, first_pending = 1'b0;

  always @(negedge aclk) begin
    cyc = cyc + 1;
    if (CS_N && !cs_prev) begin
      cs_rises    = cs_rises + 1;
      cs_rise_cyc = cyc;
    end
    if (!CS_N && cs_prev) begin
      cs_falls      = cs_falls + 1;
      last_idle_gap = cyc - cs_rise_cyc;
      cs_fall_cyc   = cyc;
      first_pending = 1'b1;
    end
    if (m_axis_tvalid && !tv_prev) tv_rise_cyc = cyc;
    if (m_axis_tvalid && m_axis_tready) got_rx.push_back(m_axis_tdata);
    if (!aresetn) begin
      tx_bits = 0;
      bitpos  = 0;
    end else if (SCLK && !sclk_prev) begin
      sclk_rises = sclk_rises + 1;
      if (first_pending) begin
        first_rise_cyc = cyc;
        first_pending  = 1'b0;
      end
      tx_sh   = {tx_sh[6:0], DIN};
      tx_bits = tx_bits + 1;
      if (tx_bits == 8) begin
        got_tx.push_back(tx_sh);
        tx_bits = 0;
      end
      if (bitpos == 0) begin
        cur_resp = (resp_rd < resp_q.size()) ? resp_q[resp_rd] : 8'd0;
        resp_rd  = resp_rd + 1;
      end
`ifdef ADS124X_SPI_LOOPBACK_EN
      DOUT = 1'b0;
`else
      DOUT = cur_resp[7 - bitpos];
`endif
      bitpos = (bitpos + 1) % 8;
    end
    sclk_prev = SCLK;
    cs_prev   = CS_N;
    tv_prev   = m_axis_tvalid;
  end

  // driver tasks
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks = checks + 1;
    assert (obs === exp_v) else begin
      errors = errors + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_byte(input logic [7:0] tx, input logic [7:0] resp);
    exp_tx_q.push_back(tx);
    resp_q.push_back(resp);
`ifdef ADS124X_SPI_LOOPBACK_EN
    exp_rx_q.push_back(tx);
`else
    exp_rx_q.push_back(resp);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    n = 0;
    tick();
    while (!s_axis_tready && n < 3000) begin
      tick();
      n++;
    end
    check("s_accept", 32'(s_axis_tready), 32'd1);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int n;
    n = 0;
    while (got_rx.size() < target && n < 5000) begin
      tick();
      n++;
    end
    check("rx_arrived", 32'(got_rx.size()), 32'(target));
  endtask

  task automatic wait_cs_high();
    int n;
    n = 0;
    while (!CS_N && n < 3000) begin
      tick();
      n++;
    end
    check("cs_release", 32'(CS_N), 32'd1);
  endtask

  task automatic compare_streams(input string tag);
    logic [7:0] e;
    check({tag, "_rx_count"}, 32'(got_rx.size() - rx_rd), 32'(exp_rx_q.size()));
    check({tag, "_tx_count"}, 32'(got_tx.size() - tx_rd), 32'(exp_tx_q.size()));
    while (exp_rx_q.size() > 0) begin
      e = exp_rx_q.pop_front();
      if (rx_rd < got_rx.size()) begin
        check({tag, "_rx_byte"}, 32'(got_rx[rx_rd]), 32'(e));
        rx_rd++;
      end
    end
    while (exp_tx_q.size() > 0) begin
      e = exp_tx_q.pop_front();
      if (tx_rd < got_tx.size()) begin
        check({tag, "_tx_byte"}, 32'(got_tx[tx_rd]), 32'(e));
        tx_rd++;
      end
    end
    rx_rd = got_rx.size();
    tx_rd = got_tx.size();
  endtask

  // directed and random steps
  initial begin
    int f0, r0, c0, rx0, viol, n;
    logic [7:0] held, b, r, e1;

    repeat (3) tick();
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_cs_n", 32'(CS_N), 32'd1);
    check("rst_din", 32'(DIN), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    aresetn = 1'b1;
    tick();

    // single byte with timing
    f0 = cs_falls; r0 = sclk_rises;
    push_byte(8'hA5, 8'h3C);
    send_byte(8'hA5);
    wait_rx(got_rx.size() + 1);
    wait_cs_high();
    tick();
    check("t1_setup_cycles", 32'(first_rise_cyc - cs_fall_cyc), 32'(SETUP));
    check("t1_byte_cycles", 32'(tv_rise_cyc - first_rise_cyc), 32'(16 * HALF + 1));
    // rx appears, is taken on the next edge, then HOLD idle cycles run before release
    check("t1_hold_cycles", 32'(cs_rise_cyc - tv_rise_cyc), 32'(HOLD + 1));
    check("t1_sclk_pulses", 32'(sclk_rises - r0), 32'd8);
    check("t1_frames", 32'(cs_falls - f0), 32'd1);
    compare_streams("t1");

    // back-to-back command in one frame
    f0 = cs_falls; r0 = sclk_rises; c0 = cs_rises;
    push_byte(8'h40, 8'h11); push_byte(8'h00, 8'h22); push_byte(8'h17, 8'h33);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h17);
    wait_rx(got_rx.size() + 3 - (got_rx.size() - rx_rd));
    wait_cs_high();
    tick();
    check("t2_frames", 32'(cs_falls - f0), 32'd1);
    check("t2_cs_rises", 32'(cs_rises - c0), 32'd1);
    check("t2_sclk_pulses", 32'(sclk_rises - r0), 32'd24);
    compare_streams("t2");

    // receive backpressure stalls the next transmit
    f0 = cs_falls; r0 = sclk_rises;
    m_axis_tready = 1'b0;
    push_byte(8'hC3, 8'h5E);
`ifdef ADS124X_SPI_LOOPBACK_EN
    e1 = 8'hC3;
`else
    e1 = 8'h5E;
`endif
    push_byte(8'h81, 8'h7A);
    send_byte(8'hC3);
    s_axis_tdata  = 8'h81;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!m_axis_tvalid && n < 3000) begin
      tick();
      n++;
    end
    check("t3_first_valid", 32'(m_axis_tvalid), 32'd1);
    held = m_axis_tdata;
    r0 = sclk_rises;
    viol = 0;
    repeat (100) begin
      tick();
      if (s_axis_tready || !m_axis_tvalid || m_axis_tdata !== held) viol++;
    end
    check("t3_stall_violations", 32'(viol), 32'd0);
    check("t3_no_sclk", 32'(sclk_rises - r0), 32'd0);
    check("t3_held_data", 32'(held), 32'(e1));
    m_axis_tready = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 3000) begin
      tick();
      n++;
    end
    check("t3_second_accept", 32'(s_axis_tready), 32'd1);
    tick();
    s_axis_tvalid = 1'b0;
    wait_rx(rx_rd + 2);
    wait_cs_high();
    tick();
    check("t3_frames", 32'(cs_falls - f0), 32'd1);
    compare_streams("t3");

    // gap beyond hold gives two frames with an idle gap
    f0 = cs_falls;
    push_byte(8'h12, 8'hE7);
    send_byte(8'h12);
    wait_rx(rx_rd + 1);
    wait_cs_high();
    repeat (3) tick();
    push_byte(8'h34, 8'h9B);
    send_byte(8'h34);
    wait_rx(rx_rd + 2);
    wait_cs_high();
    tick();
    check("t4_frames", 32'(cs_falls - f0), 32'd2);
    check("t4_idle_gap_ok", 32'(last_idle_gap >= IDLE), 32'd1);
    compare_streams("t4");

    // reset in the middle of a byte
    resp_q.push_back(8'hAA);
    send_byte(8'hFF);
    n = 0;
    while (tx_bits < 4 && n < 3000) begin
      tick();
      n++;
    end
    check("t5_reached_bit4", 32'(tx_bits), 32'd4);
    rx0 = got_rx.size();
    aresetn = 1'b0;
    tick();
    check("t5_cs_n", 32'(CS_N), 32'd1);
    check("t5_sclk", 32'(SCLK), 32'd0);
    check("t5_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    repeat (3) tick();
    aresetn = 1'b1;
    repeat (30) tick();
    check("t5_no_rx", 32'(got_rx.size() - rx0), 32'd0);
    check("t5_no_tx", 32'(got_tx.size() - tx_rd), 32'd0);
    push_byte(8'h96, 8'h69);
    send_byte(8'h96);
    wait_rx(rx_rd + 1);
    wait_cs_high();
    compare_streams("t5");

    // loopback pattern (DOUT model tied low in loopback builds)
    push_byte(8'h5A, 8'h00);
    send_byte(8'h5A);
    wait_rx(rx_rd + 1);
    wait_cs_high();
    compare_streams("t6");

    // random bytes, random gaps and random receive backpressure
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      r = 8'($urandom_range(0, 255));
      push_byte(b, r);
      m_axis_tready = 1'b1;
      send_byte(b);
      n = $urandom_range(0, 40);
      for (int k = 0; k < n; k++) begin
        m_axis_tready = 1'($urandom_range(0, 1));
        tick();
      end
    end
    m_axis_tready = 1'b1;
    wait_rx(rx_rd + 12);
    wait_cs_high();
    compare_streams("rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
